// File: rtl/snes_tst_pkg.sv
// Shared constants and types for the SNES video post-processing path:
// B-bus register addresses, default OSD window bounds and the blank pair type.
package snes_tst_pkg;

  localparam logic [7:0] INIDISP_ADDR = 8'h00;
  localparam int         BRIGHT_W     = 4;

  localparam int OSD_X1_DEF    = 64;
  localparam int OSD_X2_DEF    = 192;
  localparam int OSD_Y1_DEF    = 32;
  localparam int OSD_Y2_DEF    = 96;
  localparam int OSD_SHIFT_DEF = 2;

  typedef struct packed {
    logic hblank;
    logic vblank;
  } blank_t;

  localparam blank_t BLANK_IDLE = '{hblank: 1'b1, vblank: 1'b1};

endpackage

// File: rtl/snes_bbus_snoop.sv
// Snoops one PPU B-bus register: synchronises the write strobe, latches the
// bus while it is low and commits brightness/force-blank on its rising edge.
module snes_bbus_snoop
  import snes_tst_pkg::*;
#(
  parameter logic [7:0] MATCH_ADDR = INIDISP_ADDR,
  parameter int         BRIGHT_RST = 15
) (
  input  logic                CLK_i,
  input  logic                RST_i,
  input  logic                PAWR_N_i,
  input  logic [7:0]          PADDR_i,
  input  logic [7:0]          PDATA_i,
  output logic [BRIGHT_W-1:0] BRIGHT_o,
  output logic                FBLANK_o
);

  // [0],[1]: synchroniser stages; [2]: previous synced value for edge detect
  logic [2:0]          sync_q;
  logic [7:0]          addr_q, addr_d;
  logic [BRIGHT_W-1:0] lat_bright_q, lat_bright_d;
  logic                lat_fblank_q, lat_fblank_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic                fblank_q, fblank_d;
  logic                strobe_n, strobe_rise;

  assign strobe_n    = sync_q[1];
  assign strobe_rise = sync_q[1] & ~sync_q[2];

  // NOTE: every output of an always_comb block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    addr_d       = addr_q;
    lat_bright_d = lat_bright_q;
    lat_fblank_d = lat_fblank_q;
    bright_d     = bright_q;
    fblank_d     = fblank_q;
    if (!strobe_n) begin
      addr_d       = PADDR_i;
      lat_bright_d = PDATA_i[BRIGHT_W-1:0];
      lat_fblank_d = PDATA_i[7];
    end
    if (strobe_rise && addr_q == MATCH_ADDR) begin
      bright_d = lat_bright_q;
      fblank_d = lat_fblank_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      sync_q       <= 3'b111;
      addr_q       <= '0;
      lat_bright_q <= '0;
      lat_fblank_q <= 1'b0;
      bright_q     <= BRIGHT_W'(BRIGHT_RST);
      fblank_q     <= 1'b0;
    end else begin
      sync_q       <= {sync_q[1:0], PAWR_N_i};
      addr_q       <= addr_d;
      lat_bright_q <= lat_bright_d;
      lat_fblank_q <= lat_fblank_d;
      bright_q     <= bright_d;
      fblank_q     <= fblank_d;
    end
  end

  assign BRIGHT_o = bright_q;
  assign FBLANK_o = fblank_q;

endmodule

// File: rtl/snes_video_proc.sv
// PPU RGB to DAC path: INIDISP brightness scaling, H/V position tracking and
// OSD window dimming. Define VIDPROC_FBLANK_EN to blank colour on force-blank.
module snes_video_proc
  import snes_tst_pkg::*;
#(
  parameter int IN_W       = 5,
  parameter int OUT_W      = 9,
  parameter int H_W        = 11,
  parameter int V_W        = 9,
  parameter int H_DIV      = 4,
  parameter int OSD_X1     = OSD_X1_DEF,
  parameter int OSD_X2     = OSD_X2_DEF,
  parameter int OSD_Y1     = OSD_Y1_DEF,
  parameter int OSD_Y2     = OSD_Y2_DEF,
  parameter int OSD_SHIFT  = OSD_SHIFT_DEF,
  parameter int BRIGHT_RST = 15
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic             PAWR_N_i,
  input  logic [7:0]       PADDR_i,
  input  logic [7:0]       PDATA_i,
  input  logic             HBLANK_i,
  input  logic             VBLANK_i,
  input  logic             OSD_EN_i,
  input  logic [IN_W-1:0]  R_i,
  input  logic [IN_W-1:0]  G_i,
  input  logic [IN_W-1:0]  B_i,
  output logic [OUT_W-1:0] R_o,
  output logic [OUT_W-1:0] G_o,
  output logic [OUT_W-1:0] B_o,
  output logic             HBLANK_o,
  output logic             VBLANK_o,
  output logic [3:0]       BRIGHT_o,
  output logic             FBLANK_o,
  output logic [H_W-1:0]   H_CNT_o,
  output logic [V_W-1:0]   V_CNT_o
);

  localparam int P_W  = IN_W + BRIGHT_W;
  localparam int PS_W = (H_DIV > 1) ? $clog2(H_DIV) : 1;

  logic [BRIGHT_W-1:0] bright;
  logic                fblank;

  snes_bbus_snoop #(
    .MATCH_ADDR (INIDISP_ADDR),
    .BRIGHT_RST (BRIGHT_RST)
  ) u_inidisp (
    .CLK_i    (CLK_i),
    .RST_i    (RST_i),
    .PAWR_N_i (PAWR_N_i),
    .PADDR_i  (PADDR_i),
    .PDATA_i  (PDATA_i),
    .BRIGHT_o (bright),
    .FBLANK_o (fblank)
  );

  logic [PS_W-1:0] ps_q, ps_d;
  logic [H_W-1:0]  h_q, h_d;
  logic [V_W-1:0]  v_q, v_d;
  logic            hb_prev_q;

  always_comb begin
    ps_d = ps_q;
    h_d  = h_q;
    v_d  = v_q;
    if (HBLANK_i) begin
      ps_d = '0;
      h_d  = H_W'(1);
    end else if (ps_q == PS_W'(H_DIV - 1)) begin
      ps_d = '0;
      if (h_q != '1) h_d = h_q + 1'b1;
    end else begin
      ps_d = ps_q + 1'b1;
    end
    // VBLANK has priority over a coincident line start
    if (VBLANK_i) begin
      v_d = '0;
    end else if (HBLANK_i && !hb_prev_q && v_q != '1) begin
      v_d = v_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      ps_q      <= '0;
      h_q       <= H_W'(1);
      v_q       <= '0;
      hb_prev_q <= 1'b1;
    end else begin
      ps_q      <= ps_d;
      h_q       <= h_d;
      v_q       <= v_d;
      hb_prev_q <= HBLANK_i;
    end
  end

  logic in_win;
  assign in_win = OSD_EN_i
                & (h_q >  H_W'(OSD_X1)) & (h_q <= H_W'(OSD_X2))
                & (v_q >  V_W'(OSD_Y1)) & (v_q <= V_W'(OSD_Y2));

  function automatic logic [OUT_W-1:0] scale(input logic [IN_W-1:0]     c,
                                             input logic                win,
                                             input logic [BRIGHT_W-1:0] br);
    logic [IN_W-1:0]      cs;
    logic [P_W-1:0]       prod;
    logic [P_W+OUT_W-1:0] wide;
    cs   = win ? (c >> OSD_SHIFT) : c;
    prod = P_W'(cs) * P_W'(br);
    wide = (P_W + OUT_W)'(prod);
    return wide[OUT_W-1:0];
  endfunction

  logic [IN_W-1:0]  r1_q, g1_q, b1_q;
  logic             win1_q;
  blank_t           blank1_q, blank2_q;
  logic [OUT_W-1:0] r2_q, g2_q, b2_q;
  logic [OUT_W-1:0] r2_d, g2_d, b2_d;

  always_comb begin
    r2_d = scale(r1_q, win1_q, bright);
    g2_d = scale(g1_q, win1_q, bright);
    b2_d = scale(b1_q, win1_q, bright);
`ifdef VIDPROC_FBLANK_EN
    if (fblank) begin
      r2_d = '0;
      g2_d = '0;
      b2_d = '0;
    end
`endif
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r1_q     <= '0;
      g1_q     <= '0;
      b1_q     <= '0;
      win1_q   <= 1'b0;
      blank1_q <= BLANK_IDLE;
      r2_q     <= '0;
      g2_q     <= '0;
      b2_q     <= '0;
      blank2_q <= BLANK_IDLE;
    end else begin
      r1_q     <= R_i;
      g1_q     <= G_i;
      b1_q     <= B_i;
      win1_q   <= in_win;
      blank1_q <= '{hblank: HBLANK_i, vblank: VBLANK_i};
      r2_q     <= r2_d;
      g2_q     <= g2_d;
      b2_q     <= b2_d;
      blank2_q <= blank1_q;
    end
  end

  assign R_o      = r2_q;
  assign G_o      = g2_q;
  assign B_o      = b2_q;
  assign HBLANK_o = blank2_q.hblank;
  assign VBLANK_o = blank2_q.vblank;
  assign BRIGHT_o = bright;
  assign FBLANK_o = fblank;
  assign H_CNT_o  = h_q;
  assign V_CNT_o  = v_q;

endmodule

// File: doc/snes_video_proc.md
Name: snes_video_proc

Overview:
- Parametrised successor to the board's inline RGB brightness/OSD path.
- Snoops PPU B-bus writes to INIDISP ($2100) to recover master brightness and force-blank.
- Tracks H/V position from the HBLANK/VBLANK strobes and scales the 5-bit PPU RGB into the DAC width.
- Dims pixels inside a parametrised OSD window; sits between the TST_R/G/B inputs and the RDIG/GDIG/BDIG DAC outputs.

Parameters:
- IN_W, 5, per-channel PPU colour width.
- OUT_W, 9, per-channel DAC width; product is zero-extended or MSB-truncated to OUT_W.
- H_W, 11, horizontal counter width.
- V_W, 9, vertical counter width.
- H_DIV, 4, master clocks per horizontal count step (≥1).
- OSD_X1, 64, window left bound (exclusive).
- OSD_X2, 192, window right bound (inclusive).
- OSD_Y1, 32, window top bound (exclusive).
- OSD_Y2, 96, window bottom bound (inclusive).
- OSD_SHIFT, 2, right-shift applied to in-window colour before scaling.
- BRIGHT_RST, 15, brightness value after reset.

Ports:
- CLK_i  in  1  master clock (MCLK domain).
- RST_i  in  1  asynchronous active-high reset.
- PAWR_N_i  in  1  B-bus write strobe, active low, asynchronous to CLK_i.
- PADDR_i  in  8  B-bus address.
- PDATA_i  in  8  B-bus data.
- HBLANK_i  in  1  PPU horizontal blank.
- VBLANK_i  in  1  PPU vertical blank.
- OSD_EN_i  in  1  window dimming enable.
- R_i, G_i, B_i  in  IN_W each  PPU colour.
- R_o, G_o, B_o  out  OUT_W each  scaled colour, registered.
- HBLANK_o, VBLANK_o  out  1 each  blanks delayed to match colour latency.
- BRIGHT_o  out  4  current brightness.
- FBLANK_o  out  1  current force-blank bit.
- H_CNT_o  out  H_W  horizontal position.
- V_CNT_o  out  V_W  vertical position.

Behaviour:
- Reset (async, RST_i=1) values:
  - R_o/G_o/B_o = 0; HBLANK_o = VBLANK_o = 1.
  - BRIGHT_o = BRIGHT_RST; FBLANK_o = 0.
  - H_CNT_o = 1; V_CNT_o = 0; prescaler = 0.
  - Snoop synchronisers reset to 1 (idle).
- Snoop:
  - PAWR_N_i passes through a 2-flop synchroniser.
  - While the synced strobe is low, PADDR_i/PDATA_i are registered every cycle (the last sample wins).
  - On the synced rising edge, if the latched address == 8'h00: BRIGHT ← data[3:0], FBLANK ← data[7]. Other addresses are ignored.
  - Commit happens 3 cycles after the raw strobe rises.
  - A strobe shorter than 2 cycles may be missed; this is accepted.
- H counter:
  - While HBLANK_i = 1: H_CNT = 1, prescaler = 0.
  - Otherwise the prescaler counts 0..H_DIV-1; H_CNT increments when the prescaler = H_DIV-1.
  - H_CNT saturates at its all-ones value (no wrap).
- V counter:
  - While VBLANK_i = 1: V_CNT = 0.
  - Otherwise it increments once per HBLANK_i rising edge (edge detected against a registered copy), saturating at all-ones.
  - If VBLANK and an HBLANK edge occur in the same cycle, VBLANK wins.
- Colour pipeline, latency 2 cycles from R/G/B_i to R/G/B_o:
  - Stage 1 registers colour, blanks, and in_win = OSD_EN_i & (H_CNT > OSD_X1) & (H_CNT ≤ OSD_X2) & (V_CNT > OSD_Y1) & (V_CNT ≤ OSD_Y2), evaluated on the current counter values.
  - Stage 2 output = (in_win ? c >> OSD_SHIFT : c) × BRIGHT, unsigned, computed at IN_W+4 bits and then resized to OUT_W.
  - BRIGHT is sampled at stage 2, so a brightness change affects output on the next cycle.
  - The HBLANK_o/VBLANK_o delays match the 2-cycle latency.
- Brightness 0 gives 0 output. Colour is not forced to 0 during blanking (the DAC blanks it).

Optional Feature:
- Macro: VIDPROC_FBLANK_EN.
- Defined: when FBLANK is 1, stage 2 drives R/G/B_o = 0 regardless of colour or brightness; the counters are unaffected.
- Undefined: FBLANK_o is still tracked and reported, but the colour path ignores it.

Decomposition:
- Package snes_tst_pkg holds:
  - localparam INIDISP_ADDR = 8'h00;
  - default window bounds;
  - the brightness width constant BRIGHT_W = 4.
- One natural sub-module, snes_bbus_snoop (synchroniser, latch, commit, brightness/fblank registers). It is reusable for the $2105/$211A snooping the top still does inline.

Test Plan:
- Reset, R/G/B_i = 31 → after 2 cycles R_o = 465 (31×15), BRIGHT_o = 15, FBLANK_o = 0, H_CNT_o = 1, V_CNT_o = 0.
- Write 8'h07 to PADDR 8'h00 (strobe low 6 cycles) → BRIGHT_o = 7 three cycles after the strobe rises, R_o = 217 for R_i = 31. Write 8'h0F to PADDR 8'h05 → BRIGHT unchanged.
- OSD_EN_i = 1, drive HBLANK/VBLANK so that H_CNT = 100 and V_CNT = 50, G_i = 20, BRIGHT = 15 → G_o = 75. Same stimulus with OSD_EN_i = 0 → G_o = 300.
- Window boundaries: H_CNT = 64 → undimmed; H_CNT = 65 → dimmed; H_CNT = 192 → dimmed; H_CNT = 193 → undimmed (same checks on V at 32/33/96/97).
- Hold HBLANK_i/VBLANK_i low for more than 2^H_W × H_DIV cycles → H_CNT_o stays at 2047. Assert VBLANK_i together with an HBLANK rising edge → V_CNT_o = 0.
- With VIDPROC_FBLANK_EN defined, write 8'h8F → R/G/B_o = 0, BRIGHT_o = 15. Without the macro, same write → R_o = 465. Assert RST_i mid-strobe → no commit, BRIGHT_o = 15.
